mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4-to-1 mux datapath among 4 requesters.
//   Grants exactly one requester at a time and drives the mux select lines (sel -> S).
//   Optionally caps ownership with a hold timeout so no requester starves the others.
//   Sits directly in front of the 4:1 mux; all outputs are registered.
// PARAMETERS
//   MAX_HOLD  8  max consecutive grant cycles while others wait; 0 = no timeout
//   CNT_W     8  hold-counter width; MAX_HOLD must be < 2**CNT_W
// PORTS
//   clk      in   1  single clock; all state changes on rising edge
//   rst_n    in   1  asynchronous active-low reset
//   en       in   1  arbitration enable; low = no new grants
//   req      in   4  request per requester, level; held high until done
//   gnt      out  4  one-hot grant, or 4'b0000 when idle
//   sel      out  2  index of current/last owner; drives mux S[1:0]
//   busy     out  1  1 while any gnt bit is set
//   preempt  out  1  1-cycle pulse on the cycle after a timeout-forced switch
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - gnt=0, sel=0, busy=0, preempt=0, hold_cnt=0, state=IDLE, last=3.
//   - Priority after reset therefore starts at requester 0.
//   FSM has two states: IDLE and GRANT.
//   IDLE:
//   - If en=1 and req!=0, grant the first set req bit scanning last+1, last+2, ... mod 4.
//   - Next edge: gnt, sel and busy update; state=GRANT; last=winner; hold_cnt=0.
//   - Latency from req to gnt is 1 clock.
//   - If en=0 or req=0, stay in IDLE. sel keeps its previous value (no glitch on S).
//   GRANT, owner o:
//   - While req[o]=1, keep the grant; hold_cnt increments each cycle.
//   - Release: req[o]=0 is sampled. On the same edge, re-arbitrate among the other
//     req bits starting at o+1, with zero bubble. If en=0 or none pending, go to IDLE
//     with gnt=0.
//   - Timeout applies only when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
//     - Another req is pending and en=1: force the grant to the next RR winner; preempt=1
//       for one cycle. The old owner stays requesting and re-enters rotation.
//     - No other req is pending: the owner keeps the grant and hold_cnt wraps to 0.
//   - en=0 during GRANT: the current owner keeps the grant until release. Timeout
//     switching is suppressed; the owner keeps the grant and hold_cnt wraps to 0.
//   Invariants:
//   - gnt is always one-hot or zero.
//   - busy == |gnt.
//   - sel == index of the set gnt bit whenever busy=1.
//   Simultaneous events:
//   - Release and timeout on the same edge are handled as a release; preempt=0.
//   - A req bit that rises in the same cycle as arbitration is eligible.
//   - A non-owner dropping its req before being granted is simply ignored.
//   Reset mid-grant: outputs clear immediately (async). The RR pointer returns to last=3.
// TESTING
//   1. Hold rst_n=0 with req=4'hF -> gnt=0, sel=0, busy=0. Release, en=1 ->
//      next edge gnt=4'b0001, sel=0.
//   2. req=4'b0100 only, hold 3 cycles, then drop -> gnt=4'b0100 and sel=2 one cycle
//      after req; gnt=0 and busy=0 one cycle after the drop.
//   3. req=4'hF; each owner drops req 2 cycles after being granted, then re-raises ->
//      grant order 0,1,2,3,0; no idle cycle between owners.
//   4. MAX_HOLD=8, req=4'b0011, owner 0 never drops -> after 8 grant cycles gnt=4'b0010,
//      preempt=1 for 1 cycle; then owner 1 is bounded the same way and the grant
//      returns to 0.
//   5. en=0 while owner 2 holds, req=4'b1100 -> owner 2 keeps the grant past MAX_HOLD,
//      preempt stays 0. After owner 2 drops, gnt=0 and owner 3 is not granted until en=1.
//   6. Async rst_n pulse mid-cycle while gnt=4'b1000 -> gnt=0 immediately. After release
//      with req=4'b1001, the first grant goes to requester 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux datapath.
// Registered one-hot grant and mux select, with an optional hold timeout.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_e           state_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [3:0]       gnt_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic             preempt_q;

  logic [3:0] cand;
  logic       win_found;
  logic [1:0] win_idx;
  logic       owner_req;
  logic       timeout;
  logic       do_grant;
  logic       do_preempt;
  logic       go_idle;

  // The current owner is masked out, so a timeout always hands over to someone else.
  always_comb begin
    cand      = req & ~gnt_q;
    owner_req = req[sel_q];
    timeout   = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast);
    win_found = 1'b0;
    win_idx   = last_q;
    for (int i = 1; i <= 4; i++) begin
      if (!win_found && cand[last_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = last_q + 2'(i);
      end
    end
  end

  always_comb begin
    do_grant   = 1'b0;
    do_preempt = 1'b0;
    go_idle    = 1'b0;
    case (state_q)
      StIdle: do_grant = en && win_found;
      StGrant: begin
        if (!owner_req) begin
          do_grant = en && win_found;
          go_idle  = !(en && win_found);
        end else if (timeout) begin
          do_grant   = en && win_found;
          do_preempt = en && win_found;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= do_preempt;
      if (do_grant) begin
        state_q    <= StGrant;
        gnt_q      <= 4'b0001 << win_idx;
        sel_q      <= win_idx;
        busy_q     <= 1'b1;
        last_q     <= win_idx;
        hold_cnt_q <= '0;
      end else if (go_idle) begin
        // sel is left alone so the mux select does not move while idle.
        state_q    <= StIdle;
        gnt_q      <= 4'b0000;
        busy_q     <= 1'b0;
        hold_cnt_q <= '0;
      end else if (state_q == StGrant) begin
        hold_cnt_q <= timeout ? '0 : hold_cnt_q + 1'b1;
      end
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: per-cycle expectations are queued and
// compared one clock later against the registered outputs.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;
  } obs_t;

  obs_t sb[$];

  mux4_rr_arbiter #(
    .MAX_HOLD(8),
    .CNT_W   (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .req    (req),
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input obs_t exp);
    obs_t obs;
    obs = '{gnt: gnt, sel: sel, busy: busy, preempt: preempt};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed gnt=%b sel=%0d busy=%b preempt=%b, expected gnt=%b sel=%0d busy=%b preempt=%b",
             tag, obs.gnt, obs.sel, obs.busy, obs.preempt,
             exp.gnt, exp.sel, exp.busy, exp.preempt);
    end
  endtask

  // Queue the expectation for the next edge, advance one clock, then compare.
  task automatic tick(input string tag, input logic [3:0] g, input logic [1:0] s,
                      input logic p);
    obs_t e;
    e = '{gnt: g, sel: s, busy: (g != 4'b0000), preempt: p};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag, sb.pop_front());
  endtask

  task automatic sync_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("reset_assert", '{gnt: 4'b0000, sel: 2'd0, busy: 1'b0, preempt: 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset with all requests high, then first grant goes to requester 0
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'hF;
    #1;
    check("t1_reset", '{gnt: 4'b0000, sel: 2'd0, busy: 1'b0, preempt: 1'b0});
    repeat (2) @(posedge clk);
    #1;
    check("t1_reset_held", '{gnt: 4'b0000, sel: 2'd0, busy: 1'b0, preempt: 1'b0});
    rst_n = 1'b1;
    tick("t1_first_grant", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick("t1_release_idle", 4'b0000, 2'd0, 1'b0);

    // 2: single requester 2, three cycles, then drop; sel holds in idle
    req = 4'b0100;
    for (int i = 0; i < 3; i++) tick("t2_grant2", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    tick("t2_drop_idle", 4'b0000, 2'd2, 1'b0);
    tick("t2_sel_hold", 4'b0000, 2'd2, 1'b0);

    // 3: full rotation with zero-bubble hand-over
    sync_reset();
    req = 4'hF;
    tick("t3_own0_a", 4'b0001, 2'd0, 1'b0);
    tick("t3_own0_b", 4'b0001, 2'd0, 1'b0);
    req = 4'b1110;
    tick("t3_own1_a", 4'b0010, 2'd1, 1'b0);
    req = 4'hF;
    tick("t3_own1_b", 4'b0010, 2'd1, 1'b0);
    req = 4'b1101;
    tick("t3_own2_a", 4'b0100, 2'd2, 1'b0);
    req = 4'hF;
    tick("t3_own2_b", 4'b0100, 2'd2, 1'b0);
    req = 4'b1011;
    tick("t3_own3_a", 4'b1000, 2'd3, 1'b0);
    req = 4'hF;
    tick("t3_own3_b", 4'b1000, 2'd3, 1'b0);
    req = 4'b0111;
    tick("t3_own0_again", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick("t3_idle", 4'b0000, 2'd0, 1'b0);

    // 4: hold timeout bounces ownership between 0 and 1
    sync_reset();
    req = 4'b0011;
    for (int i = 0; i < 8; i++) tick("t4_own0_hold", 4'b0001, 2'd0, 1'b0);
    tick("t4_preempt_to1", 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 7; i++) tick("t4_own1_hold", 4'b0010, 2'd1, 1'b0);
    tick("t4_preempt_to0", 4'b0001, 2'd0, 1'b1);
    tick("t4_pulse_end", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick("t4_idle", 4'b0000, 2'd0, 1'b0);

    // 5: en low suppresses timeout switching and new grants
    req = 4'b0100;
    tick("t5_grant2", 4'b0100, 2'd2, 1'b0);
    en  = 1'b0;
    req = 4'b1100;
    for (int i = 0; i < 12; i++) tick("t5_hold_past_max", 4'b0100, 2'd2, 1'b0);
    req = 4'b1000;
    tick("t5_drop_idle", 4'b0000, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) tick("t5_no_grant_en0", 4'b0000, 2'd2, 1'b0);
    en = 1'b1;
    tick("t5_grant3", 4'b1000, 2'd3, 1'b0);

    // 6: asynchronous reset pulse mid-cycle, pointer returns to requester 0
    #2;
    req   = 4'b1001;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", '{gnt: 4'b0000, sel: 2'd0, busy: 1'b0, preempt: 1'b0});
    #1;
    rst_n = 1'b1;
    tick("t6_first_grant0", 4'b0001, 2'd0, 1'b0);
    req = 4'b1000;
    tick("t6_handover3", 4'b1000, 2'd3, 1'b0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
